d_cfir_coe_sequencer: RTL and testbench
=======================================

D_CFIR_COE_SEQUENCER -- requirements
Module: d_cfir_coe_sequencer

Interface
REQ-001 SHALL have parameter WORDS_PER_FRAME, default 4, meaning the number of 23-bit sdi words sent per coefficient update.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum WAIT_ACK cycles allowed before an error.
REQ-003 SHALL have port CLK  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_we  input  1  coefficient table write enable.
REQ-006 SHALL have port cfg_addr  input  6  table word address (profile = addr[5:2], word = addr[1:0]).
REQ-007 SHALL have port cfg_wdata  input  23  table write data.
REQ-008 SHALL have port start  input  1  single-cycle request to load a profile.
REQ-009 SHALL have port profile_id  input  4  profile to load, sampled with start.
REQ-010 SHALL have port sel_next  input  6  datapath tap select to apply after load, sampled with start.
REQ-011 SHALL have port coe_load  input  1  load acknowledge pulse from the coefficient update block.
REQ-012 SHALL have port ssb  output  1  active-low serial frame strobe to the coefficient update block.
REQ-013 SHALL have port sdi  output  23  serial data word.
REQ-014 SHALL have port sel  output  6  tap select to the CFIR datapath.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on successful load.
REQ-017 SHALL have port err  output  1  one-cycle pulse on acknowledge timeout.
REQ-018 SHALL have port start_drop  output  1  one-cycle pulse when start arrives while busy.

Function
REQ-019 SHALL hold a 64 x 23 coefficient table, written on cfg_we at any time, including while busy.
REQ-020 SHALL implement the FSM IDLE -> FRAME -> WAIT_ACK -> IDLE.
REQ-021 SHALL, on start in IDLE at cycle t, latch profile_id and sel_next and enter FRAME at t+1.
REQ-022 SHALL, in FRAME, drive ssb=0 for cycles t+1..t+4, with sdi = table[{profile_id, n}] at frame cycle n (n = 0..3).
REQ-023 SHALL read each table word in the cycle it is driven; a same-cycle write to the same address SHALL send the old data.
REQ-024 SHALL, after the last frame word, drive ssb=1 and sdi=0 and enter WAIT_ACK.
REQ-025 SHALL ignore coe_load outside WAIT_ACK.
REQ-026 SHALL, when coe_load is sampled high in WAIT_ACK at cycle k, update sel to the latched sel_next, pulse done, and return to IDLE, all at k+1.
REQ-027 SHALL, when WAIT_ACK lasts ACK_TIMEOUT cycles without coe_load, pulse err, leave sel unchanged, and return to IDLE.
REQ-028 SHALL treat coe_load arriving in the same cycle as the timeout as success: done pulses, err does not.
REQ-029 SHALL, on start while busy, leave the operation in flight undisturbed and pulse start_drop the next cycle.
REQ-030 SHALL accept a start in the same cycle busy falls, since that cycle is IDLE.
REQ-031 SHALL hold sdi=0 and ssb=1 whenever the FSM is not in FRAME.

Reset
REQ-032 SHALL set on rst: state=IDLE, ssb=1, sdi=0, sel=0, busy=0, done=0, err=0, start_drop=0, and clear the timeout counter.
REQ-033 SHALL, on rst asserted mid-FRAME or mid-WAIT_ACK, abort the operation with ssb=1 at the next edge and no done or err pulse.
REQ-034 SHALL NOT clear the table contents on rst.

Structure
REQ-035 SHALL place in the shared package d_cfir_pkg: the FSM state encoding, WORDS_PER_FRAME, ACK_TIMEOUT, and the table width and depth constants.
REQ-036 SHALL implement the table as the sub-module d_cfir_coe_table, a 64x23 register file with a synchronous write port and a combinational read port.

Verification
REQ-037 SHALL verify nominal load: write profile 3 words 0x000001..0x000004, start with sel_next=0x15, ack 3 cycles after the frame -> ssb low for 4 cycles with sdi 1,2,3,4, then sel=0x15 and a done pulse one cycle after ack.
REQ-038 SHALL verify timeout: start with no coe_load -> err pulses 16 cycles after WAIT_ACK entry, sel stays 0, busy falls.
REQ-039 SHALL verify busy collision: a second start during FRAME -> start_drop pulses once and the first frame's sdi sequence is unchanged.
REQ-040 SHALL verify write hazard: write 0x7FFFFF to the word being sent in that same cycle -> old value on sdi, new value on the next load.
REQ-041 SHALL verify mid-operation reset: rst during frame word 2 -> ssb=1, sel=0, no done or err; a subsequent start completes normally.
REQ-042 SHALL verify ack/timeout tie: coe_load on the 16th WAIT_ACK cycle -> done=1, err=0.

Source files
------------

// File: rtl/d_cfir_pkg.sv
// Shared constants and FSM encoding for the CFIR coefficient sequencer.
package d_cfir_pkg;

    localparam int WORDS_PER_FRAME = 4;
    localparam int ACK_TIMEOUT     = 16;
    localparam int TBL_W           = 23;
    localparam int TBL_DEPTH       = 64;
    localparam int TBL_AW          = $clog2(TBL_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FRAME    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

endpackage

// File: rtl/d_cfir_coe_table.sv
// Coefficient register file: synchronous write, combinational read.
module d_cfir_coe_table
    import d_cfir_pkg::*;
(
    input  logic              CLK,
    input  logic              we,
    input  logic [TBL_AW-1:0] waddr,
    input  logic [TBL_W-1:0]  wdata,
    input  logic [TBL_AW-1:0] raddr,
    output logic [TBL_W-1:0]  rdata
);

    // No reset: contents survive rst so profiles need not be rewritten.
    logic [TBL_W-1:0] mem [TBL_DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/d_cfir_coe_sequencer.sv
// Streams one coefficient profile to the update block as an ssb-framed word burst,
// then waits for the load acknowledge before switching the datapath tap select.
module d_cfir_coe_sequencer #(
    parameter int WORDS_PER_FRAME = d_cfir_pkg::WORDS_PER_FRAME,
    parameter int ACK_TIMEOUT     = d_cfir_pkg::ACK_TIMEOUT
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [5:0]  cfg_addr,
    input  logic [22:0] cfg_wdata,
    input  logic        start,
    input  logic [3:0]  profile_id,
    input  logic [5:0]  sel_next,
    input  logic        coe_load,
    output logic        ssb,
    output logic [22:0] sdi,
    output logic [5:0]  sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        start_drop
);

    import d_cfir_pkg::*;

    localparam int WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int CW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_FRAME - 1);
    localparam logic [CW-1:0]  LAST_WAIT = CW'(ACK_TIMEOUT - 1);

    state_t            state;
    logic [WCW-1:0]    word;
    logic [CW-1:0]     ack_cnt;
    logic [3:0]        prof;
    logic [5:0]        sel_lat;
    logic [TBL_AW-1:0] raddr;
    logic [TBL_W-1:0]  rdata;

    d_cfir_coe_table u_table (
        .CLK   (CLK),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign raddr = TBL_AW'(int'(prof) * WORDS_PER_FRAME + int'(word));

    // Word is read in the cycle it is driven, so a colliding write sends old data.
    assign sdi = (state == ST_FRAME) ? rdata : '0;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= ST_IDLE;
            ssb        <= 1'b1;
            sel        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            start_drop <= 1'b0;
            word       <= '0;
            ack_cnt    <= '0;
            prof       <= '0;
            sel_lat    <= '0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            start_drop <= start && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        prof    <= profile_id;
                        sel_lat <= sel_next;
                        word    <= '0;
                        ssb     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (word == LAST_WORD) begin
                        ssb     <= 1'b1;
                        ack_cnt <= '0;
                        state   <= ST_WAIT_ACK;
                    end else begin
                        word <= word + 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (coe_load) begin
                        sel   <= sel_lat;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (ack_cnt == LAST_WAIT) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                default: begin
                    ssb   <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_cfir_coe_sequencer.sv
// Scoreboard bench: a timeline reference model queues expected frame words,
// completions and drops; a negedge monitor pops and compares them.
module tb_d_cfir_coe_sequencer;

    localparam int WPF = 4;
    localparam int TMO = 16;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [22:0] cfg_wdata = '0;
    logic        start = 1'b0;
    logic [3:0]  profile_id = '0;
    logic [5:0]  sel_next = '0;
    logic        coe_load = 1'b0;
    logic        ssb;
    logic [22:0] sdi;
    logic [5:0]  sel;
    logic        busy, done, err, start_drop;

    d_cfir_coe_sequencer #(.WORDS_PER_FRAME(WPF), .ACK_TIMEOUT(TMO)) dut (
        .CLK(CLK), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .profile_id(profile_id), .sel_next(sel_next), .coe_load(coe_load),
        .ssb(ssb), .sdi(sdi), .sel(sel), .busy(busy), .done(done), .err(err),
        .start_drop(start_drop)
    );

    always #5 CLK = ~CLK;

    typedef struct { int cyc; logic [22:0] d; } sdi_exp_t;
    typedef struct { int cyc; int kind; logic [5:0] sel; } evt_exp_t;

    sdi_exp_t q_sdi[$];
    evt_exp_t q_evt[$];
    int       q_drop[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    // Reference model state
    logic [22:0] mtbl [64];
    logic        op_active = 1'b0;
    int          op_t = 0, op_end = 0;
    logic [3:0]  op_pid = '0;
    logic [5:0]  op_sel = '0;
    logic [5:0]  sel_now = '0;
    logic        sel_upd_pend = 1'b0;
    int          sel_upd_cyc = 0;
    logic [5:0]  sel_upd_val = '0;
    logic        rst_prev = 1'b0;
    logic        exp_busy = 1'b0;
    logic [5:0]  exp_sel = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: apply inputs and advance the reference model by the spec's timeline.
    task automatic step(input logic s, input logic [3:0] pid, input logic [5:0] sn,
                        input logic ack, input logic we, input logic [5:0] a,
                        input logic [22:0] d, input logic r);
        int c, n;
        c = cyc;
        if (sel_upd_pend && c == sel_upd_cyc) begin
            sel_now = sel_upd_val;
            sel_upd_pend = 1'b0;
        end
        if (op_active && c == op_end) op_active = 1'b0;
        if (rst_prev) begin
            op_active = 1'b0;
            sel_now = '0;
            sel_upd_pend = 1'b0;
        end
        start = s; profile_id = pid; sel_next = sn; coe_load = ack;
        cfg_we = we; cfg_addr = a; cfg_wdata = d; rst = r;
        exp_busy = op_active && (c > op_t);
        exp_sel = sel_now;
        if (exp_busy) begin
            n = c - op_t - 1;
            if (n < WPF) begin
                q_sdi.push_back('{c, mtbl[int'(op_pid) * WPF + n]});
            end else if (!r) begin
                if (ack) begin
                    q_evt.push_back('{c + 1, 1, op_sel});
                    sel_upd_pend = 1'b1;
                    sel_upd_cyc = c + 1;
                    sel_upd_val = op_sel;
                    op_end = c + 1;
                end else if (n - (WPF - 1) == TMO) begin
                    q_evt.push_back('{c + 1, 2, sel_now});
                    op_end = c + 1;
                end
            end
        end
        if (s && !r) begin
            if (exp_busy) q_drop.push_back(c + 1);
            else begin
                op_active = 1'b1; op_t = c; op_end = 1 << 30; op_pid = pid; op_sel = sn;
            end
        end
        if (we) mtbl[a] = d;
        rst_prev = r;
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [22:0] d);
        step(0, 0, 0, 0, 1, a, d, 0);
    endtask

    task automatic go(input logic [3:0] pid, input logic [5:0] sn);
        step(1, pid, sn, 0, 0, 0, 0, 0);
    endtask

    task automatic ack1();
        step(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (!ssb) begin
                chk("frame_word_expected", q_sdi.size() > 0, 1);
                if (q_sdi.size() > 0) begin
                    sdi_exp_t e;
                    e = q_sdi.pop_front();
                    chk("frame_word_cycle", cyc, e.cyc);
                    chk("sdi_word", sdi, e.d);
                end
            end else begin
                chk("sdi_idle_zero", sdi, 0);
            end
            if (done || err) begin
                chk("completion_expected", q_evt.size() > 0, 1);
                if (q_evt.size() > 0) begin
                    evt_exp_t e;
                    e = q_evt.pop_front();
                    chk("completion_cycle", cyc, e.cyc);
                    chk("completion_kind", {err, done}, e.kind);
                    chk("sel_after_completion", sel, e.sel);
                end
            end
            if (start_drop) begin
                chk("start_drop_expected", q_drop.size() > 0, 1);
                if (q_drop.size() > 0) chk("start_drop_cycle", cyc, q_drop.pop_front());
            end
            chk("busy", busy, exp_busy);
            chk("sel", sel, exp_sel);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ssb", ssb, 1);
        chk("reset_sdi", sdi, 0);
        chk("reset_sel", sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_start_drop", start_drop, 0);
        rst_prev = 1'b1;
        mon_en = 1'b1;
        rst = 1'b0;

        for (int i = 0; i < 64; i++) wr(6'(i), 23'($urandom));

        // Timeout, with stray acks during the frame that must be ignored
        go(4'd7, 6'h2A);
        for (int i = 0; i < WPF; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        idle(TMO + 3);

        // Nominal load of profile 3
        for (int i = 0; i < 4; i++) wr(6'(12 + i), 23'(i + 1));
        go(4'd3, 6'h15);
        idle(WPF + 2);
        ack1();
        idle(3);

        // Collision during the frame
        go(4'd5, 6'h0A);
        go(4'd9, 6'h33);
        idle(WPF + 1);
        ack1();
        idle(2);

        // Write hazard on frame word 2
        go(4'd3, 6'h21);
        idle(2);
        wr(6'd14, 23'h7FFFFF);
        idle(WPF);
        ack1();
        go(4'd3, 6'h22);
        idle(WPF + 1);
        ack1();
        idle(2);

        // Reset during frame word 2, then a normal load
        go(4'd2, 6'h11);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        go(4'd2, 6'h12);
        idle(WPF + 3);
        ack1();
        idle(2);

        // Ack on the final WAIT_ACK cycle
        go(4'd1, 6'h3C);
        idle(WPF + TMO - 1);
        ack1();
        idle(2);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 7) == 0), 4'($urandom), 6'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                 6'($urandom), 23'($urandom), ($urandom_range(0, 99) == 0));
        end

        idle(WPF + TMO + 5);
        chk("sdi_queue_drained", q_sdi.size(), 0);
        chk("completion_queue_drained", q_evt.size(), 0);
        chk("drop_queue_drained", q_drop.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
